// File: rtl/sram_mp_arb_if.sv
// Avalon-MM bus bundle for the shared multi-port SRAM.
// Per-port fields are packed; port i occupies slice [i*W +: W].
interface sram_mp_arb_if #(
  parameter int NUM_PORTS = 4,
  parameter int DATA_W    = 16,
  parameter int ADDR_W    = 14,
  parameter int BE_W      = DATA_W / 8
);
  logic [NUM_PORTS*ADDR_W-1:0] address;
  logic [NUM_PORTS*BE_W-1:0]   byteenable;
  logic [NUM_PORTS-1:0]        chipselect;
  logic [NUM_PORTS-1:0]        read;
  logic [NUM_PORTS-1:0]        write;
  logic [NUM_PORTS*DATA_W-1:0] writedata;
  logic [NUM_PORTS*DATA_W-1:0] readdata;
  logic [NUM_PORTS-1:0]        readdatavalid;
  logic [NUM_PORTS-1:0]        waitrequest;

  modport master (
    output address, byteenable, chipselect,
    output read, write, writedata,
    input  readdata, readdatavalid, waitrequest
  );

  modport slave (
    input  address, byteenable, chipselect,
    input  read, write, writedata,
    output readdata, readdatavalid, waitrequest
  );
endinterface

// File: rtl/sram_mp_arb.sv
// Shared SRAM, round-robin arbitrated Avalon-MM ports, clear engine.
// Define SRAM_MP_ARB_PERF_EN for per-port stall counters.
module sram_mp_arb #(
  parameter int NUM_PORTS    = 4,
  parameter int DATA_W       = 16,
  parameter int DEPTH        = 16384,
  parameter int ADDR_W       = $clog2(DEPTH),
  parameter int BE_W         = DATA_W / 8,
  parameter int READ_LATENCY = 1
) (
  input  logic clk,
  input  logic reset_n,
  sram_mp_arb_if.slave bus,
  input  logic clear_req,
  output logic busy,
  output logic clear_done
`ifdef SRAM_MP_ARB_PERF_EN
  ,
  output logic [NUM_PORTS*32-1:0] stall_cnt
`endif
);

  localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int RL = READ_LATENCY;

  typedef enum logic [1:0] {IDLE, CLEAR, DONE} state_t;

  state_t state, state_nx;
  logic [ADDR_W-1:0] clr_addr;
  logic [PW-1:0] ptr, gidx;
  logic [NUM_PORTS-1:0] req, grant, wreq;
  logic gvld, acc, acc_wr, acc_rd;
  logic [ADDR_W-1:0] acc_addr;
  logic [DATA_W-1:0] acc_wdata;
  logic [BE_W-1:0] acc_be;

  logic [DATA_W-1:0] mem [DEPTH];

  logic [RL-1:0] p_vld;
  logic [PW-1:0] p_port [RL];
  logic [DATA_W-1:0] p_data [RL];

  logic [NUM_PORTS*DATA_W-1:0] rd_q;
  logic [NUM_PORTS-1:0] rdv_q;

  assign req = bus.chipselect & (bus.read | bus.write);

  always_comb begin : rr_blk
    int idx;
    idx   = 0;
    grant = '0;
    gidx  = '0;
    gvld  = 1'b0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      idx = (int'(ptr) + k) % NUM_PORTS;
      if (!gvld && req[idx]) begin
        gvld       = 1'b1;
        gidx       = PW'(idx);
        grant[idx] = 1'b1;
      end
    end
  end

  // a clear request in the same cycle pre-empts any port
  assign acc = gvld & (state == IDLE) & ~clear_req & reset_n;
  assign acc_wr = acc & bus.write[gidx];
  assign acc_rd = acc & ~bus.write[gidx];
  assign acc_addr = bus.address[int'(gidx)*ADDR_W +: ADDR_W];
  assign acc_wdata = bus.writedata[int'(gidx)*DATA_W +: DATA_W];
  assign acc_be = bus.byteenable[int'(gidx)*BE_W +: BE_W];

  assign wreq = reset_n ? (req & ~(grant & {NUM_PORTS{acc}})) : '1;
  assign bus.waitrequest = wreq;
  assign bus.readdata = rd_q;
  assign bus.readdatavalid = rdv_q;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ptr <= '0;
    end else if (acc) begin
      ptr <= (gidx == PW'(NUM_PORTS - 1)) ? '0 : gidx + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset_n) begin
      if (state == CLEAR) begin
        mem[clr_addr] <= '0;
      end else if (acc_wr) begin
        for (int b = 0; b < BE_W; b++) begin
          if (acc_be[b]) mem[acc_addr][b*8 +: 8] <= acc_wdata[b*8 +: 8];
        end
      end
    end
    if (acc_rd) p_data[0] <= mem[acc_addr];
    for (int k = 1; k < RL; k++) p_data[k] <= p_data[k-1];
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      p_vld <= '0;
      for (int k = 0; k < RL; k++) p_port[k] <= '0;
      rd_q  <= '0;
      rdv_q <= '0;
    end else begin
      p_vld[0]  <= acc_rd;
      p_port[0] <= gidx;
      for (int k = 1; k < RL; k++) begin
        p_vld[k]  <= p_vld[k-1];
        p_port[k] <= p_port[k-1];
      end
      rdv_q <= '0;
      if (p_vld[RL-1]) begin
        rdv_q[p_port[RL-1]] <= 1'b1;
        rd_q[int'(p_port[RL-1])*DATA_W +: DATA_W] <= p_data[RL-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state    <= IDLE;
      clr_addr <= '0;
    end else begin
      state <= state_nx;
      if (state == CLEAR) clr_addr <= clr_addr + 1'b1;
      else clr_addr <= '0;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:  if (clear_req) state_nx = CLEAR;
      CLEAR: if (clr_addr == ADDR_W'(DEPTH - 1)) state_nx = DONE;
      DONE:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    busy       = 1'b0;
    clear_done = 1'b0;
    unique case (1'b1)
      (state == CLEAR): busy = 1'b1;
      (state == DONE):  clear_done = 1'b1;
      default: ;
    endcase
  end

`ifdef SRAM_MP_ARB_PERF_EN
  logic [31:0] stall_q [NUM_PORTS];

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_PORTS; i++) stall_q[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        if (req[i] && wreq[i] && stall_q[i] != 32'hFFFF_FFFF)
          stall_q[i] <= stall_q[i] + 32'd1;
      end
    end
  end

  always_comb begin
    stall_cnt = '0;
    for (int i = 0; i < NUM_PORTS; i++) stall_cnt[i*32 +: 32] = stall_q[i];
  end
`endif

endmodule

// File: tb/tb_sram_mp_arb.sv
// Directed bench for sram_mp_arb: one latency-1 and one latency-2
// instance, both DEPTH=64, four 16-bit ports.
module tb_sram_mp_arb;
  localparam int NP = 4;
  localparam int DW = 16;
  localparam int DEP = 64;
  localparam int AW = 6;
  localparam int BW = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset_n;
  logic clr_a, busy_a, done_a;
  logic clr_b, busy_b, done_b;

  sram_mp_arb_if #(.NUM_PORTS(NP), .DATA_W(DW), .ADDR_W(AW), .BE_W(BW)) bus_a ();
  sram_mp_arb_if #(.NUM_PORTS(NP), .DATA_W(DW), .ADDR_W(AW), .BE_W(BW)) bus_b ();

`ifdef SRAM_MP_ARB_PERF_EN
  logic [NP*32-1:0] st_a, st_b;
`endif

  sram_mp_arb #(
    .NUM_PORTS(NP), .DATA_W(DW), .DEPTH(DEP), .READ_LATENCY(1)
  ) dut_a (
    .clk(clk), .reset_n(reset_n), .bus(bus_a),
    .clear_req(clr_a), .busy(busy_a), .clear_done(done_a)
`ifdef SRAM_MP_ARB_PERF_EN
    , .stall_cnt(st_a)
`endif
  );

  sram_mp_arb #(
    .NUM_PORTS(NP), .DATA_W(DW), .DEPTH(DEP), .READ_LATENCY(2)
  ) dut_b (
    .clk(clk), .reset_n(reset_n), .bus(bus_b),
    .clear_req(clr_b), .busy(busy_b), .clear_done(done_b)
`ifdef SRAM_MP_ARB_PERF_EN
    , .stall_cnt(st_b)
`endif
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(int p, bit wr, bit rd, logic [AW-1:0] a,
                       logic [DW-1:0] d, logic [BW-1:0] be);
    bus_a.chipselect[p] = wr | rd;
    bus_a.write[p] = wr;
    bus_a.read[p] = rd;
    bus_a.address[p*AW +: AW] = a;
    bus_a.writedata[p*DW +: DW] = d;
    bus_a.byteenable[p*BW +: BW] = be;
  endtask

  task automatic wait_acc(int p, string tag);
    int n = 0;
    #1;
    while (bus_a.waitrequest[p] && n < 300) begin
      tick();
      n++;
    end
    if (bus_a.waitrequest[p]) check({tag, "_timeout"}, bus_a.waitrequest[p], 0);
    tick();
  endtask

  task automatic wr_a(int p, logic [AW-1:0] a, logic [DW-1:0] d, logic [BW-1:0] be);
    drive(p, 1, 0, a, d, be);
    wait_acc(p, "wr");
    drive(p, 0, 0, 0, 0, 0);
  endtask

  task automatic rd_a(int p, logic [AW-1:0] a, output logic [DW-1:0] q,
                      output logic v0, output logic v);
    drive(p, 0, 1, a, 0, 0);
    wait_acc(p, "rd");
    drive(p, 0, 0, 0, 0, 0);
    v0 = bus_a.readdatavalid[p];
    tick();
    v = bus_a.readdatavalid[p];
    q = bus_a.readdata[p*DW +: DW];
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] q;
    logic v0, v;
    int busy_n, stall_n, done_n, nz, nv;

    reset_n = 1'b0;
    clr_a = 1'b0;
    clr_b = 1'b0;
    bus_a.address = '0; bus_a.byteenable = '0; bus_a.chipselect = '0;
    bus_a.read = '0; bus_a.write = '0; bus_a.writedata = '0;
    bus_b.address = '0; bus_b.byteenable = '0; bus_b.chipselect = '0;
    bus_b.read = '0; bus_b.write = '0; bus_b.writedata = '0;
    tick();
    tick();

    check("rst_waitreq", bus_a.waitrequest, 4'hF);
    check("rst_busy", busy_a, 0);
    check("rst_done", done_a, 0);
    check("rst_rdv", bus_a.readdatavalid, 0);
    check("rst_rdata", bus_a.readdata, 0);
    reset_n = 1'b1;
    tick();
    check("idle_waitreq", bus_a.waitrequest, 0);

    // basic write then read, latency 1
    wr_a(0, 6'h10, 16'hA5A5, 2'b11);
    rd_a(0, 6'h10, q, v0, v);
    check("rd10_early", v0, 0);
    check("rd10_valid", v, 1);
    check("rd10_data", q, 16'hA5A5);
    tick();
    check("rdv_pulse", bus_a.readdatavalid[0], 0);
    check("rd_hold", bus_a.readdata[15:0], 16'hA5A5);

    // byte-lane merge
    wr_a(0, 6'd5, 16'h1234, 2'b11);
    wr_a(0, 6'd5, 16'hFFFF, 2'b10);
    rd_a(0, 6'd5, q, v0, v);
    check("be_merge", q, 16'hFF34);

    // read and write together: write wins, no read completion
    drive(0, 1, 1, 6'd9, 16'hBEEF, 2'b11);
    wait_acc(0, "rw");
    drive(0, 0, 0, 0, 0, 0);
    tick();
    check("rw_no_rdv", bus_a.readdatavalid[0], 0);
    rd_a(0, 6'd9, q, v0, v);
    check("rw_data", q, 16'hBEEF);

    // round robin with all four ports requesting from reset
    reset_n = 1'b0;
    for (int p = 0; p < NP; p++) drive(p, 0, 1, AW'(p), 0, 0);
    tick();
    reset_n = 1'b1;
    #1;
    for (int c = 0; c < 8; c++) begin
      logic [3:0] e;
      e = 4'hF ^ (4'b0001 << (c % 4));
      check($sformatf("rr_cyc%0d", c), bus_a.waitrequest, e);
      tick();
    end
    for (int p = 0; p < NP; p++) drive(p, 0, 0, 0, 0, 0);
    tick();
    tick();

    // fill, then clear while port 1 requests
    for (int i = 0; i < DEP; i++) wr_a(0, AW'(i), DW'((i + 1) * 257), 2'b11);
    clr_a = 1'b1;
    drive(1, 0, 1, 6'd7, 0, 0);
    #1;
    check("clr_wins", bus_a.waitrequest[1], 1);
    tick();
    clr_a = 1'b0;
    busy_n = 0;
    stall_n = 0;
    for (int c = 0; c < DEP; c++) begin
      busy_n += int'(busy_a);
      stall_n += int'(bus_a.waitrequest[1]);
      tick();
    end
    check("clr_busy_cycles", busy_n, DEP);
    check("clr_stall_cycles", stall_n, DEP);
    check("clr_done_pulse", done_a, 1);
    check("clr_done_busy", busy_a, 0);
    check("clr_done_stall", bus_a.waitrequest[1], 1);
    tick();
    check("clr_done_once", done_a, 0);
    wait_acc(1, "p1_after_clr");
    drive(1, 0, 0, 0, 0, 0);
    tick();
    check("p1_rdv", bus_a.readdatavalid[1], 1);
    check("p1_data", bus_a.readdata[31:16], 0);
    nz = 0;
    nv = 0;
    for (int i = 0; i < DEP; i++) begin
      rd_a(0, AW'(i), q, v0, v);
      nv += int'(v);
      if (q != 0) nz++;
    end
    check("clr_all_valid", nv, DEP);
    check("clr_all_zero", nz, 0);

    // reset during sweep
    wr_a(0, 6'd3, 16'h3333, 2'b11);
    wr_a(0, 6'd20, 16'h2020, 2'b11);
    clr_a = 1'b1;
    tick();
    clr_a = 1'b0;
    check("sweep_busy", busy_a, 1);
    repeat (9) tick();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    check("abort_busy", busy_a, 0);
    done_n = 0;
    repeat (70) begin
      done_n += int'(done_a);
      tick();
    end
    check("abort_no_done", done_n, 0);
    rd_a(0, 6'd3, q, v0, v);
    check("abort_w3", q, 0);
    rd_a(0, 6'd20, q, v0, v);
    check("abort_w20", q, 16'h2020);

    // latency 2 on port 2 of the second instance
    for (int k = 1; k <= 3; k++) begin
      bus_b.chipselect[2] = 1'b1;
      bus_b.write[2] = 1'b1;
      bus_b.byteenable[5:4] = 2'b11;
      bus_b.address[17:12] = AW'(k);
      bus_b.writedata[47:32] = DW'(k * 16'h1111);
      #1;
      check($sformatf("l2_wr%0d_wait", k), bus_b.waitrequest[2], 0);
      tick();
    end
    bus_b.write[2] = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      bus_b.chipselect[2] = 1'b1;
      bus_b.read[2] = 1'b1;
      bus_b.address[17:12] = AW'(k);
      #1;
      check($sformatf("l2_rd%0d_wait", k), bus_b.waitrequest[2], 0);
      check($sformatf("l2_rd%0d_early", k), bus_b.readdatavalid, 0);
      tick();
    end
    bus_b.chipselect[2] = 1'b0;
    bus_b.read[2] = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      check($sformatf("l2_rdv%0d", k), bus_b.readdatavalid, 4'b0100);
      check($sformatf("l2_data%0d", k), bus_b.readdata[47:32], DW'(k * 16'h1111));
      tick();
    end
    check("l2_rdv_end", bus_b.readdatavalid, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
